// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF measurement sequencer.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam int CLEAR_CYCLES  = 2;
    localparam int DEF_SEL_W     = 4;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_RESP_BITS = 8;

endpackage

// File: rtl/ro_puf_pair_sel.sv
// Oscillator pair selection for response bit k; bank B is bumped off bank A on collision.
module ro_puf_pair_sel #(
    parameter int SEL_W = 4,
    parameter int K_W   = 3
) (
    input  logic [2*SEL_W-1:0] challenge,
    input  logic [K_W-1:0]     k,
    output logic [SEL_W-1:0]   sel_a,
    output logic [SEL_W-1:0]   sel_b
);
    logic [SEL_W-1:0] raw_b;

    always_comb begin
        sel_a = challenge[SEL_W-1:0] + SEL_W'(k);
        raw_b = challenge[2*SEL_W-1:SEL_W] + SEL_W'(k);
        sel_b = (raw_b == sel_a) ? sel_a + SEL_W'(1) : raw_b;
    end

endmodule

// File: rtl/ro_puf_meas_ctrl.sv
// Sequences clear / enable / settle / sample for each response bit and returns
// the assembled response over a valid/ready handshake.
module ro_puf_meas_ctrl
    import ro_puf_pkg::*;
#(
    parameter int RESP_BITS = DEF_RESP_BITS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WIN_W     = 16,
    parameter int SEL_W     = DEF_SEL_W,
    parameter int SETTLE    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2*SEL_W-1:0]   challenge,
    input  logic [WIN_W-1:0]     win_len,
    output logic                 busy,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie
);
    localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    state_t               state;
    logic [K_W-1:0]       k;
    logic [WIN_W-1:0]     timer;
    logic [WIN_W-1:0]     win_q;
    logic [2*SEL_W-1:0]   chal_q;
    logic [2*SEL_W-1:0]   ps_chal;
    logic [K_W-1:0]       ps_k;
    logic [SEL_W-1:0]     ps_a;
    logic [SEL_W-1:0]     ps_b;

    // In IDLE the selector looks at the live challenge so bit 0 is ready on accept;
    // otherwise it precomputes the pair for the next bit.
    assign ps_chal = (state == S_IDLE) ? challenge : chal_q;
    assign ps_k    = (state == S_IDLE) ? '0 : k + K_W'(1);

    ro_puf_pair_sel #(.SEL_W(SEL_W), .K_W(K_W)) u_pair_sel (
        .challenge (ps_chal),
        .k         (ps_k),
        .sel_a     (ps_a),
        .sel_b     (ps_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            k          <= '0;
            timer      <= '0;
            win_q      <= '0;
            chal_q     <= '0;
            busy       <= 1'b0;
            ro_en      <= 1'b0;
            cnt_clr    <= 1'b0;
            sel_a      <= '0;
            sel_b      <= '0;
            resp       <= '0;
            resp_valid <= 1'b0;
            tie        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state   <= S_CLEAR;
                    chal_q  <= challenge;
                    win_q   <= (win_len == '0) ? WIN_W'(1) : win_len;
                    k       <= '0;
                    resp    <= '0;
                    tie     <= 1'b0;
                    busy    <= 1'b1;
                    cnt_clr <= 1'b1;
                    timer   <= WIN_W'(CLEAR_CYCLES - 1);
                    sel_a   <= ps_a;
                    sel_b   <= ps_b;
                end
                S_CLEAR: if (timer == '0) begin
                    state   <= S_RUN;
                    cnt_clr <= 1'b0;
                    ro_en   <= 1'b1;
                    timer   <= win_q - WIN_W'(1);
                end else begin
                    timer   <= timer - WIN_W'(1);
                end
                S_RUN: if (timer == '0) begin
                    state   <= S_SETTLE;
                    ro_en   <= 1'b0;
                    timer   <= WIN_W'(SETTLE - 1);
                end else begin
                    timer   <= timer - WIN_W'(1);
                end
                S_SETTLE: if (timer == '0) begin
                    state   <= S_SAMPLE;
                end else begin
                    timer   <= timer - WIN_W'(1);
                end
                S_SAMPLE: begin
                    resp[k] <= (cnt_a > cnt_b);
                    if (cnt_a == cnt_b) tie <= 1'b1;
                    if (k == K_W'(RESP_BITS - 1)) begin
                        state      <= S_DONE;
                        resp_valid <= 1'b1;
                    end else begin
                        state   <= S_CLEAR;
                        k       <= k + K_W'(1);
                        cnt_clr <= 1'b1;
                        timer   <= WIN_W'(CLEAR_CYCLES - 1);
                        sel_a   <= ps_a;
                        sel_b   <= ps_b;
                    end
                end
                S_DONE: if (resp_ready) begin
                    state      <= S_IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_puf_meas_ctrl.sv
// Directed bench for ro_puf_meas_ctrl with a behavioural RO count model and
// scoreboards for expected responses and oscillator pairs.
module tb_ro_puf_meas_ctrl;
    localparam int RB = 8, CW = 16, WW = 16, SW = 4, ST = 4;

    logic clk = 1'b0;
    logic rst_n, start, resp_ready;
    logic busy, ro_en, cnt_clr, resp_valid, tie;
    logic [7:0]    challenge;
    logic [WW-1:0] win_len;
    logic [SW-1:0] sel_a, sel_b;
    logic [CW-1:0] cnt_a, cnt_b;
    logic [RB-1:0] resp;

    always #5 clk = ~clk;

    ro_puf_meas_ctrl #(.RESP_BITS(RB), .CNT_W(CW), .WIN_W(WW), .SEL_W(SW), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .win_len(win_len),
        .busy(busy), .ro_en(ro_en), .cnt_clr(cnt_clr), .sel_a(sel_a), .sel_b(sel_b),
        .cnt_a(cnt_a), .cnt_b(cnt_b), .resp(resp), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .tie(tie)
    );

    int n_cmp = 0, n_err = 0;
    typedef struct packed { logic [RB-1:0] resp; logic tie; } exp_t;
    exp_t       resp_q[$];
    logic [7:0] sel_q[$];
    logic [7:0] cur_ch = 8'h00;
    int         cur_mode = 0;
    int         exp_w = 1;
    logic [3:0] kb;

    // Count model: bit index recovered from bank A select relative to the challenge base.
    always_comb begin
        kb    = sel_a - cur_ch[3:0];
        cnt_a = 16'd200;
        cnt_b = 16'd150;
        if (cur_mode == 1 && kb[0]) cnt_a = 16'd100;
        if (cur_mode == 2 && kb == 4'd3) begin
            cnt_a = 16'd100;
            cnt_b = 16'd100;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic       prev_en = 1'b0;
    int         run_len = 0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_en = 1'b0;
            run_len = 0;
            sel_q.delete();
        end else begin
            chk("no_overlap", {31'b0, cnt_clr & ro_en}, 32'd0);
            if (ro_en) begin
                if (!prev_en) begin
                    if (sel_q.size() == 0) chk("sel_q_empty", 32'd1, 32'd0);
                    else begin
                        held = sel_q.pop_front();
                        chk("sel_pair", {24'b0, sel_a, sel_b}, {24'b0, held});
                    end
                end else begin
                    chk("sel_stable", {24'b0, sel_a, sel_b}, {24'b0, held});
                end
                run_len++;
            end else if (prev_en) begin
                chk("run_len", run_len, exp_w);
                run_len = 0;
            end
            prev_en = ro_en;
        end
    end

    task automatic drive_start(input logic [7:0] ch, input logic [WW-1:0] w, input int md);
        exp_t       e;
        logic [3:0] sa, sb;
        cur_ch   = ch;
        cur_mode = md;
        exp_w    = (w == 0) ? 1 : int'(w);
        e.resp   = '0;
        e.tie    = (md == 2);
        for (int i = 0; i < RB; i++) begin
            e.resp[i] = (md == 0) ? 1'b1 : (md == 1) ? (i % 2 == 0) : (i != 3);
            sa = 4'(ch[3:0] + i);
            sb = 4'(ch[7:4] + i);
            if (sb == sa) sb = sa + 4'd1;
            sel_q.push_back({sa, sb});
        end
        resp_q.push_back(e);
        challenge = ch;
        win_len   = w;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_accept", {31'b0, busy}, 32'd1);
        chk("clr_accept", {31'b0, cnt_clr}, 32'd1);
    endtask

    task automatic wait_done(input int pulse_at);
        int   n = 0;
        exp_t e;
        while (resp_valid !== 1'b1 && n < 3000) begin
            if (n == pulse_at) begin
                start     = 1'b1;
                challenge = 8'h99;
            end else start = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("latency", n, RB * (exp_w + ST + 3));
        if (resp_q.size() == 0) chk("resp_q_empty", 32'd1, 32'd0);
        else begin
            e = resp_q.pop_front();
            chk("resp", {24'b0, resp}, {24'b0, e.resp});
            chk("tie", {31'b0, tie}, {31'b0, e.tie});
        end
    endtask

    task automatic ack();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("valid_drop", {31'b0, resp_valid}, 32'd0);
        chk("busy_drop", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int found;
        rst_n = 1'b0; start = 1'b1; resp_ready = 1'b0; challenge = 8'hFF; win_len = 16'd5;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_busy", {31'b0, busy}, 32'd0);
        end
        chk("rst_outs", {24'b0, ro_en, cnt_clr, resp_valid, tie, 4'b0}, 32'd0);
        chk("rst_resp", {24'b0, resp}, 32'd0);
        chk("rst_sel", {24'b0, sel_a, sel_b}, 32'd0);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", {31'b0, busy}, 32'd0);

        // Nominal: all a > b
        drive_start(8'h30, 16'd10, 0);
        wait_done(-1);
        ack();

        // Collision / wrap, with a stray start pulse mid-run
        drive_start(8'hEE, 16'd3, 1);
        wait_done(15);
        ack();

        // Tie on bit 3, then backpressure and simultaneous ready+start
        drive_start(8'h52, 16'd2, 2);
        wait_done(-1);
        repeat (20) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'b0, resp_valid}, 32'd1);
            chk("bp_resp", {24'b0, resp}, 32'hF7);
        end
        resp_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0; start = 1'b0;
        chk("rdy_start_valid", {31'b0, resp_valid}, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("no_restart", {31'b0, busy}, 32'd0);
        end
        chk("held_resp", {24'b0, resp}, 32'hF7);
        chk("held_tie", {31'b0, tie}, 32'd1);

        // Zero window: one enable cycle per bit
        drive_start(8'h21, 16'd0, 0);
        wait_done(-1);
        ack();

        // Abort during RUN of bit 4
        drive_start(8'h30, 16'd10, 0);
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++) begin
            @(posedge clk); #1;
            if (sel_a == 4'd4 && ro_en) found = 1;
        end
        chk("reach_bit4", found, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ro_en", {31'b0, ro_en}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_resp", {24'b0, resp}, 32'd0);
        chk("abort_valid", {31'b0, resp_valid}, 32'd0);
        resp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_abort_idle", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ro_puf_meas_ctrl.md
Name: ro_puf_meas_ctrl

Overview:
Measurement sequencer for the ring-oscillator PUF datapath: RO banks, 16:1 selection mux and ripple counters.
- For each response bit, selects an oscillator pair, clears the counters, enables the oscillators for a programmed window, lets the counters settle, then compares the two counts.
- Shifts the comparison results into a RESP_BITS response, returned over a valid/ready handshake.
- Sits between the top-level I/O and the two RO bank/counter instances.

Parameters:
RESP_BITS, 8, response bits produced per challenge
CNT_W, 16, counter width
WIN_W, 16, window-length register width
SEL_W, 4, mux select width (16 oscillators per bank)
SETTLE, 4, clk cycles between ro_en deassert and sampling (counter ripple settle)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
start  in  1  request a measurement; accepted only in IDLE
challenge  in  8  [3:0] base index bank A, [7:4] base index bank B; captured on accept
win_len  in  WIN_W  enable window in clk cycles; captured on accept; 0 treated as 1
busy  out  1  high in every state except IDLE
ro_en  out  1  oscillator enable to both banks
cnt_clr  out  1  counter clear to both counters
sel_a  out  SEL_W  bank A oscillator select
sel_b  out  SEL_W  bank B oscillator select
cnt_a  in  CNT_W  bank A count; stable when ro_en low for SETTLE cycles
cnt_b  in  CNT_W  bank B count; same condition
resp  out  RESP_BITS  response word
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
tie  out  1  sticky: some pair gave cnt_a == cnt_b in this response

Behaviour:
- All outputs registered. On rst_n low at a clk edge: state=IDLE, bit index k=0; busy, ro_en, cnt_clr, resp_valid, tie all 0; resp, sel_a, sel_b all 0. Reset mid-measurement aborts at once, with ro_en low from the next edge and no partial response.
- States and transitions:
  - IDLE: start high -> CLEAR. On that edge, latch challenge and win_len (0 -> 1), k=0, resp=0, tie=0.
  - CLEAR (2 cycles): cnt_clr=1, ro_en=0. sel_a/sel_b already valid for bit k -> RUN.
  - RUN (W cycles, W = latched win_len): ro_en=1, cnt_clr=0 -> SETTLE.
  - SETTLE (SETTLE cycles): ro_en=0 -> SAMPLE.
  - SAMPLE (1 cycle): resp[k] = (cnt_a > cnt_b), unsigned. If equal, resp[k]=0 and tie set. If k==RESP_BITS-1 -> DONE, else k++ -> CLEAR.
  - DONE: resp_valid=1, with resp and tie held stable. resp_valid & resp_ready -> IDLE, resp_valid=0 on the next edge. resp and tie keep their values until the next accepted start.
- Pair selection for bit k:
  - sel_a = (challenge[3:0] + k) mod 16
  - sel_b = (challenge[7:4] + k) mod 16; if sel_b == sel_a, then sel_b = (sel_a + 1) mod 16
  - Index wrap-around is modulo 16.
- Timing:
  - Per-bit cost is W + SETTLE + 3 cycles.
  - resp_valid rises RESP_BITS*(W+SETTLE+3) cycles after the start-accept edge.
  - sel_a/sel_b change only on the SAMPLE->CLEAR edge, never while ro_en is high.
- Boundaries and simultaneous events:
  - start while busy: ignored, not queued.
  - start and resp_ready both high in DONE: handshake completes and start is ignored; a new start is needed in IDLE.
  - resp_ready high outside DONE: no effect.
  - win_len=0: one RUN cycle.
  - win_len at maximum (2^WIN_W - 1): no overflow of the window counter; count down from W-1 to 0.
  - cnt_clr and ro_en are never high together.

Decomposition:
- Package ro_puf_pkg holds:
  - state enum (IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE)
  - CLEAR_CYCLES=2
  - default SEL_W/CNT_W/RESP_BITS constants
- Sub-module ro_puf_pair_sel: combinational; inputs challenge and k; outputs sel_a and sel_b, including the collision bump. Its outputs are registered in the controller.

Test Plan:
- Reset idle: rst_n low 3 cycles with start high -> all outputs 0, busy stays 0.
- Nominal: challenge=8'h30, win_len=10, SETTLE=4, cnt_a=200 > cnt_b=150 for all bits -> resp_valid at cycle 136 after accept, resp=8'hFF, tie=0; sel_a steps 0..7, sel_b steps 3..10.
- Collision and wrap: challenge=8'hEE -> bit0 sel_a=14, sel_b=15; bit2 sel_a=0, sel_b=1; model counts give resp=8'h55 when a>b on even k only.
- Tie: cnt_a=cnt_b=100 on bit 3 only, else a>b -> resp=8'hF7, tie=1.
- Handshake and backpressure: resp_ready low 20 cycles in DONE -> resp and resp_valid stable. Then ready=1 together with start=1 -> IDLE, no new run until start re-pulsed. start pulses during RUN are ignored.
- Abort and edge windows: rst_n low during RUN of bit 4 -> ro_en=0 next edge, busy=0, resp=0. win_len=0 -> exactly 1 ro_en cycle per bit. Check cnt_clr and ro_en never overlap throughout.
